// File: rtl/bka_pkg.sv
`default_nettype none
// ============================================================================
// bka_pkg -- shared types and helpers for the pipelined Brent-Kung adder
// Rev 1.0
// ============================================================================
package bka_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Generate/propagate pair carried through the prefix network.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int up_levels(input int width);
        return $clog2(width);
    endfunction

    function automatic int dn_levels(input int width);
        return $clog2(width) - 1;
    endfunction

    function automatic gp_t bk_cell(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bka_pipe_adder_if.sv
`default_nettype none
// ============================================================================
// bka_pipe_adder_if -- operand/result handshake bundle of bka_pipe_adder
// Ovf exists only when BKA_PIPE_OVF_EN is defined.  Rev 1.0
// ============================================================================
interface bka_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef BKA_PIPE_OVF_EN
    logic             Ovf;

    modport master (output in_valid, A, B, Cin, Sub, out_ready,
                    input  in_ready, out_valid, Sum, Cout, Ovf);
    modport slave  (input  in_valid, A, B, Cin, Sub, out_ready,
                    output in_ready, out_valid, Sum, Cout, Ovf);
`else
    modport master (output in_valid, A, B, Cin, Sub, out_ready,
                    input  in_ready, out_valid, Sum, Cout);
    modport slave  (input  in_valid, A, B, Cin, Sub, out_ready,
                    output in_ready, out_valid, Sum, Cout);
`endif
endinterface
`default_nettype wire

// File: rtl/bka_prefix_tree.sv
`default_nettype none
// ============================================================================
// bka_prefix_tree -- Brent-Kung up-sweep and down-sweep as two separate halves
// Rev 1.0
// ============================================================================
module bka_prefix_tree
    import bka_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  gp_t [WIDTH-1:0] i_up_gp,
    output gp_t [WIDTH-1:0] o_up_gp,
    input  gp_t [WIDTH-1:0] i_dn_gp,
    output gp_t [WIDTH-1:0] o_dn_gp
);

    localparam int c_UP = up_levels(WIDTH);
    localparam int c_DN = dn_levels(WIDTH);

    // Up-sweep: level l combines bit i with bit i-2^l where i+1 is a multiple of 2^(l+1).
    for (genvar l = 0; l < c_UP; l++) begin : g_up
        localparam int c_SPAN = 1 << l;
        gp_t [WIDTH-1:0] w_prev;
        gp_t [WIDTH-1:0] w_lvl;
        if (l == 0) begin : g_first
            assign w_prev = i_up_gp;
        end else begin : g_next
            assign w_prev = g_up[l-1].w_lvl;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (2 * c_SPAN)) == 0) begin : g_cell
                assign w_lvl[i] = bk_cell(w_prev[i], w_prev[i-c_SPAN]);
            end else begin : g_pass
                assign w_lvl[i] = w_prev[i];
            end
        end
    end

    assign o_up_gp = g_up[c_UP-1].w_lvl;

    // Down-sweep fills the remaining prefixes, widest span first.
    for (genvar k = 0; k < c_DN; k++) begin : g_dn
        localparam int c_SPAN = 1 << (c_DN - 1 - k);
        gp_t [WIDTH-1:0] w_prev;
        gp_t [WIDTH-1:0] w_lvl;
        if (k == 0) begin : g_first
            assign w_prev = i_dn_gp;
        end else begin : g_next
            assign w_prev = g_dn[k-1].w_lvl;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((((i + 1) % (2 * c_SPAN)) == c_SPAN) && ((i + 1) > (2 * c_SPAN))) begin : g_cell
                assign w_lvl[i] = bk_cell(w_prev[i], w_prev[i-c_SPAN]);
            end else begin : g_pass
                assign w_lvl[i] = w_prev[i];
            end
        end
    end

    assign o_dn_gp = g_dn[c_DN-1].w_lvl;

endmodule
`default_nettype wire

// File: rtl/bka_pipe_adder.sv
`default_nettype none
// ============================================================================
// bka_pipe_adder -- 3-stage pipelined Brent-Kung adder/subtractor, valid/ready
// Define BKA_PIPE_OVF_EN to add the signed-overflow output Ovf.  Rev 1.0
// ============================================================================
module bka_pipe_adder
    import bka_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    bka_pipe_adder_if.slave  bus
);

    logic             w_adv;
    logic [WIDTH-1:0] w_beff;
    logic [WIDTH-1:0] w_s1_pb;
    logic             w_ceff;
    gp_t  [WIDTH-1:0] w_s1_gp;
    gp_t  [WIDTH-1:0] w_up;
    gp_t  [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_pre_g;
    logic             w_unused_p;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    logic             r_s1_v, r_s2_v, r_s3_v;
    gp_t  [WIDTH-1:0] r_s1_gp;
    logic [WIDTH-1:0] r_s1_pb;
    logic             r_s1_c;
    gp_t  [WIDTH-1:0] r_s2_up;
    logic [WIDTH-1:0] r_s2_pb;
    logic             r_s2_c;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    // One advance signal moves the whole pipe, so nothing ever overtakes.
    assign w_adv         = ~r_s3_v | bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_s3_v;
    assign bus.Sum       = r_sum;
    assign bus.Cout      = r_cout;

    // Carry-in acts as g_-1, so bit 0 already carries the whole [0:-1] group.
    always_comb begin
        w_beff  = (bus.Sub == OP_SUB) ? ~bus.B : bus.B;
        w_ceff  = bus.Cin ^ (bus.Sub == OP_SUB);
        w_s1_pb = bus.A ^ w_beff;
        for (int i = 0; i < WIDTH; i++) begin
            w_s1_gp[i].g = bus.A[i] & w_beff[i];
            w_s1_gp[i].p = w_s1_pb[i];
        end
        w_s1_gp[0].g = (bus.A[0] & w_beff[0]) | (w_s1_pb[0] & w_ceff);
        w_s1_gp[0].p = 1'b0;
    end

    bka_prefix_tree #(
        .WIDTH (WIDTH)
    ) u_tree (
        .i_up_gp (r_s1_gp),
        .o_up_gp (w_up),
        .i_dn_gp (r_s2_up),
        .o_dn_gp (w_dn)
    );

    always_comb begin
        w_unused_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pre_g[i] = w_dn[i].g;
            w_unused_p = w_unused_p ^ w_dn[i].p;
        end
        w_sum  = r_s2_pb ^ {w_pre_g[WIDTH-2:0], r_s2_c};
        w_cout = w_pre_g[WIDTH-1];
    end

`ifdef BKA_PIPE_OVF_EN
    logic r_s1_am, r_s1_bm, r_s2_am, r_s2_bm, r_ovf;
    logic w_ovf;

    assign w_ovf   = (r_s2_am == r_s2_bm) & (w_sum[WIDTH-1] != r_s2_am);
    assign bus.Ovf = r_ovf;

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_am <= bus.A[WIDTH-1];
            r_s1_bm <= w_beff[WIDTH-1];
            r_s2_am <= r_s1_am;
            r_s2_bm <= r_s1_bm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
            r_s3_v <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_adv) begin
            r_s1_v <= bus.in_valid;
            r_s2_v <= r_s1_v;
            r_s3_v <= r_s2_v;
            r_sum  <= w_sum;
            r_cout <= w_cout;
        end
    end

    // Datapath flops follow the advance only; bubbles are marked by the valids.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_s1_gp <= w_s1_gp;
            r_s1_pb <= w_s1_pb;
            r_s1_c  <= w_ceff;
            r_s2_up <= w_up;
            r_s2_pb <= r_s1_pb;
            r_s2_c  <= r_s1_c;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bka_pipe_adder.sv
`default_nettype none
// ============================================================================
// tb_bka_pipe_adder -- randomized and directed bench for bka_pipe_adder (8/32/128)
// Rev 1.0
// ============================================================================
module tb_bka_pipe_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bka_pipe_adder_if #(.WIDTH(8))   bus8   ();
    bka_pipe_adder_if #(.WIDTH(32))  bus32  ();
    bka_pipe_adder_if #(.WIDTH(128)) bus128 ();

    bka_pipe_adder #(.WIDTH(8))   u_dut8   (.clk(clk), .rst(rst), .bus(bus8));
    bka_pipe_adder #(.WIDTH(32))  u_dut32  (.clk(clk), .rst(rst), .bus(bus32));
    bka_pipe_adder #(.WIDTH(128)) u_dut128 (.clk(clk), .rst(rst), .bus(bus128));

    typedef struct {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_out    = 0;
    bit          chk_lat  = 1'b0;
    bit          in_stall = 1'b0;
    logic [31:0] held_sum;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: add is a+b+cin; subtract is a-b-cin with bit w meaning "no borrow".
    function automatic exp_t ref_model(input int w, input logic [127:0] a_in, b_in,
                                       input logic cin, sub);
        logic [127:0] mask, a, b;
        logic [128:0] r;
        exp_t         e;
        mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (!sub) r = {1'b0, a} + {1'b0, b} + 129'(cin);
        else      r = (129'd1 << w) + {1'b0, a} - {1'b0, b} - 129'(cin);
        e.sum  = r[127:0] & mask;
        e.cout = r[w];
        if (!sub) e.ovf = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        else      e.ovf = (a[w-1] != b[w-1]) && (e.sum[w-1] != a[w-1]);
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // One clock of the 32-bit port: drive at negedge, evaluate both handshakes 1 ns later.
    task automatic cyc32(input logic r, iv, input logic [31:0] a, b,
                         input logic cin, sub, orr, output bit acc);
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus32.in_valid  = iv;
        bus32.A         = a;
        bus32.B         = b;
        bus32.Cin       = cin;
        bus32.Sub       = sub;
        bus32.out_ready = orr;
        #1;
        acc = 1'b0;
        if (r) begin
            q.delete();
            in_stall = 1'b0;
        end else begin
            check("in_ready", bus32.in_ready, !bus32.out_valid || orr);
            if (bus32.out_valid && !orr) begin
                if (in_stall) check("stall_sum", bus32.Sum, held_sum);
                held_sum = bus32.Sum;
                in_stall = 1'b1;
            end else begin
                in_stall = 1'b0;
            end
            if (bus32.out_valid && orr) begin
                if (q.size() == 0) begin
                    check("spurious_out", bus32.out_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    check("sum32", bus32.Sum, e.sum);
                    check("cout32", bus32.Cout, e.cout);
`ifdef BKA_PIPE_OVF_EN
                    check("ovf32", bus32.Ovf, e.ovf);
`endif
                    if (e.lat) check("latency", cyc - e.acc, 3);
                    n_out++;
                end
            end
            if (iv && bus32.in_ready) begin
                e     = ref_model(32, {96'b0, a}, {96'b0, b}, cin, sub);
                e.acc = cyc;
                e.lat = chk_lat;
                q.push_back(e);
                acc = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic dir32(input logic [31:0] a, b, input logic cin, sub,
                         input logic [31:0] es, input logic ec, eo);
        bit   acc;
        exp_t e;
        cyc32(1'b0, 1'b1, a, b, cin, sub, 1'b1, acc);
        check("dir_accept", acc, 1'b1);
        if (acc) begin
            e      = q.pop_back();
            e.sum  = {96'b0, es};
            e.cout = ec;
            e.ovf  = eo;
            q.push_back(e);
        end
    endtask

    task automatic idle32(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc32(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic beat8(input string tag, input logic [7:0] a, b, input logic cin, sub,
                         input logic [7:0] es, input logic ec, eo);
        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.A = a; bus8.B = b; bus8.Cin = cin; bus8.Sub = sub;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        @(negedge clk);
        #1 check({tag, "_early"}, bus8.out_valid, 1'b0);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, bus8.out_valid, 1'b1);
        check({tag, "_sum"}, bus8.Sum, es);
        check({tag, "_cout"}, bus8.Cout, ec);
`ifdef BKA_PIPE_OVF_EN
        check({tag, "_ovf"}, bus8.Ovf, eo);
`endif
    endtask

    task automatic beat128(input string tag, input logic [127:0] a, b, input logic cin, sub,
                           input logic [127:0] es, input logic ec, eo);
        @(negedge clk);
        bus128.in_valid = 1'b1; bus128.A = a; bus128.B = b; bus128.Cin = cin; bus128.Sub = sub;
        @(negedge clk);
        bus128.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, bus128.out_valid, 1'b1);
        check({tag, "_sum"}, bus128.Sum, es);
        check({tag, "_cout"}, bus128.Cout, ec);
`ifdef BKA_PIPE_OVF_EN
        check({tag, "_ovf"}, bus128.Ovf, eo);
`endif
    endtask

    initial begin
        bit           acc;
        logic [31:0]  pa, pb;
        logic         pc, ps, pv;
        int           base;
        exp_t         e;
        logic [127:0] ra, rb;

        bus8.in_valid   = 1'b0; bus8.A   = '0; bus8.B   = '0; bus8.Cin   = 1'b0; bus8.Sub   = 1'b0;
        bus128.in_valid = 1'b0; bus128.A = '0; bus128.B = '0; bus128.Cin = 1'b0; bus128.Sub = 1'b0;
        bus8.out_ready  = 1'b1;
        bus128.out_ready = 1'b1;

        // Reset: in_ready must stay high even with out_ready low.
        cyc32(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        cyc32(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        check("rst_out_valid", bus32.out_valid, 1'b0);
        check("rst_in_ready", bus32.in_ready, 1'b1);
        check("rst_sum", bus32.Sum, 32'h0);
        check("rst_cout", bus32.Cout, 1'b0);
        check("rst_out_valid8", bus8.out_valid, 1'b0);
        check("rst_out_valid128", bus128.out_valid, 1'b0);
`ifdef BKA_PIPE_OVF_EN
        check("rst_ovf", bus32.Ovf, 1'b0);
`endif

        chk_lat = 1'b1;
        dir32(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        dir32(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
        dir32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        dir32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        dir32(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        dir32(32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_000E, 1'b1, 1'b0);
        idle32(5);
        check("dir_drained", q.size(), 0);

        // Back-to-back stream of 8 beats at full rate.
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            cyc32(1'b0, 1'b1, rnd32(), rnd32(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b1, acc);
            check("b2b_accept", acc, 1'b1);
        end
        idle32(5);
        check("b2b_count", n_out - base, 8);

        // Three beats in flight, then a 5-cycle stall with a held 4th beat upstream.
        chk_lat = 1'b0;
        base = n_out;
        for (int i = 0; i < 3; i++) cyc32(1'b0, 1'b1, rnd32(), rnd32(), 1'b0, 1'(i), 1'b1, acc);
        pa = rnd32();
        pb = rnd32();
        for (int i = 0; i < 5; i++) begin
            cyc32(1'b0, 1'b1, pa, pb, 1'b1, 1'b0, 1'b0, acc);
            check("stall_not_taken", acc, 1'b0);
        end
        cyc32(1'b0, 1'b1, pa, pb, 1'b1, 1'b0, 1'b1, acc);
        check("release_taken", acc, 1'b1);
        idle32(6);
        check("stall_count", n_out - base, 4);
        check("stall_drained", q.size(), 0);

        // Random traffic with random back-pressure; upstream holds refused beats.
        pv = 1'b0; acc = 1'b0; pa = '0; pb = '0; pc = 1'b0; ps = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!pv || acc) begin
                pv = ($urandom_range(0, 3) != 0);
                pa = rnd32();
                pb = rnd32();
                pc = 1'($urandom_range(0, 1));
                ps = 1'($urandom_range(0, 1));
            end
            cyc32(1'b0, pv, pa, pb, pc, ps, ($urandom_range(0, 9) < 7), acc);
        end
        idle32(8);
        check("random_drained", q.size(), 0);

        // Reset with three beats in flight: nothing may come out afterwards.
        for (int i = 0; i < 3; i++) cyc32(1'b0, 1'b1, rnd32(), rnd32(), 1'b0, 1'b0, 1'b1, acc);
        cyc32(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        cyc32(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        check("midrst_out_valid", bus32.out_valid, 1'b0);
        check("midrst_sum", bus32.Sum, 32'h0);
        check("midrst_cout", bus32.Cout, 1'b0);
        idle32(5);

        // Width extremes.
        beat8("w8_max_plus1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        beat8("w8_5m7",       8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        beat8("w8_10m1b",     8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
        beat8("w8_ovf",       8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ra = 128'($urandom_range(0, 255));
            rb = 128'($urandom_range(0, 255));
            pc = 1'($urandom_range(0, 1));
            ps = 1'($urandom_range(0, 1));
            e  = ref_model(8, ra, rb, pc, ps);
            beat8("w8_rand", ra[7:0], rb[7:0], pc, ps, e.sum[7:0], e.cout, e.ovf);
        end

        beat128("w128_max_plus1", {128{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0);
        beat128("w128_5m7", 128'd5, 128'd7, 1'b0, 1'b1, {{124{1'b1}}, 4'hE}, 1'b0, 1'b0);
        beat128("w128_10m1b", 128'h10, 128'h1, 1'b1, 1'b1, 128'hE, 1'b1, 1'b0);
        beat128("w128_ovf", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, 127'b0}, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom(), $urandom()};
            pc = 1'($urandom_range(0, 1));
            ps = 1'($urandom_range(0, 1));
            e  = ref_model(128, ra, rb, pc, ps);
            beat128("w128_rand", ra, rb, pc, ps, e.sum, e.cout, e.ovf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
